// File: rtl/reg_writeback.sv
// Register-file writeback queue: merges memory-load and ALU results into one
// in-order FIFO and drains it into a registered write port.
module reg_writeback #(
   parameter int DEPTH = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_valid,
   input  logic [3:0]  mem_dst,
   input  logic [23:0] mem_data,
   output logic        mem_ready,
   input  logic        alu_valid,
   input  logic [3:0]  alu_dst,
   input  logic [23:0] alu_data,
   output logic        alu_ready,
   input  logic        hold,
   output logic        we,
   output logic [3:0]  dst,
   output logic [23:0] data,
   output logic [15:0] busy_mask,
   output logic [3:0]  count
);

   localparam int         AW      = $clog2(DEPTH);
   localparam logic [3:0] DEPTH_C = 4'(DEPTH);

   logic [3:0]    q_dst  [DEPTH];
   logic [23:0]   q_data [DEPTH];
   logic [AW-1:0] wr_ptr;
   logic [AW-1:0] rd_ptr;
   logic [AW-1:0] idx;
   logic          full;
   logic          push;
   logic          pop;
   logic [3:0]    push_dst;
   logic [23:0]   push_data;
   logic [15:0]   pend_mask;

   // Full is judged on the current count alone: a pop on the same edge never
   // makes room for a push.
   assign full      = (count == DEPTH_C);
   assign mem_ready = !full;
   assign alu_ready = !full && !mem_valid;

   assign push      = (mem_valid && mem_ready) || (alu_valid && alu_ready);
   assign push_dst  = mem_valid ? mem_dst  : alu_dst;
   assign push_data = mem_valid ? mem_data : alu_data;
   assign pop       = !hold && (count != 4'd0);

   // NOTE: queue storage has no reset; occupancy is defined solely by the
   // pointers and count, so stale contents are never observed.
   always_ff @(posedge clk) begin
      if (!rst && push) begin
         q_dst[wr_ptr]  <= push_dst;
         q_data[wr_ptr] <= push_data;
      end
   end

   // NOTE: all state uses non-blocking assignment so every register samples
   // pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
         we     <= 1'b0;
         dst    <= '0;
         data   <= '0;
      end else begin
         if (push) begin
            wr_ptr <= wr_ptr + AW'(1);
         end
         if (pop) begin
            rd_ptr <= rd_ptr + AW'(1);
            dst    <= q_dst[rd_ptr];
            data   <= q_data[rd_ptr];
            we     <= 1'b1;
         end else begin
            we     <= 1'b0;
         end
         case ({push, pop})
            2'b10:   count <= count + 4'd1;
            2'b01:   count <= count - 4'd1;
            default: count <= count;
         endcase
      end
   end

   // NOTE: every combinational output gets a default before the loop so no
   // latch is inferred for unvisited bits.
   always_comb begin
      pend_mask = '0;
      idx       = rd_ptr;
      for (int k = 0; k < DEPTH; k++) begin
         if (4'(k) < count) begin
            pend_mask[q_dst[idx]] = 1'b1;
         end
         idx = idx + AW'(1);
      end
      if (we) begin
         pend_mask[dst] = 1'b1;
      end
   end

   assign busy_mask = pend_mask;

endmodule

// File: tb/tb_reg_writeback.sv
// Self-checking bench for reg_writeback: a queue-based reference model predicts
// every output each cycle; directed scenarios add explicit constant checks.
module tb_reg_writeback;

   localparam int DEPTH = 4;

   logic        clk;
   logic        rst;
   logic        mem_valid;
   logic [3:0]  mem_dst;
   logic [23:0] mem_data;
   logic        mem_ready;
   logic        alu_valid;
   logic [3:0]  alu_dst;
   logic [23:0] alu_data;
   logic        alu_ready;
   logic        hold;
   logic        we;
   logic [3:0]  dst;
   logic [23:0] data;
   logic [15:0] busy_mask;
   logic [3:0]  count;

   int total;
   int bad;

   // Reference model: queued entries {dst, data}, the write port, and a log
   // of everything written to the register file.
   logic [27:0] q[$];
   logic [27:0] wlog[$];
   logic        m_we;
   logic [3:0]  m_dst;
   logic [23:0] m_data;
   logic        acc_mem;
   logic        acc_alu;

   logic [50:0] obs;
   assign obs = {mem_ready, alu_ready, we, dst, data, busy_mask, count};

   reg_writeback #(.DEPTH(DEPTH)) dut (
      .clk       (clk),
      .rst       (rst),
      .mem_valid (mem_valid),
      .mem_dst   (mem_dst),
      .mem_data  (mem_data),
      .mem_ready (mem_ready),
      .alu_valid (alu_valid),
      .alu_dst   (alu_dst),
      .alu_data  (alu_data),
      .alu_ready (alu_ready),
      .hold      (hold),
      .we        (we),
      .dst       (dst),
      .data      (data),
      .busy_mask (busy_mask),
      .count     (count)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   function automatic logic [50:0] exp_out();
      logic [15:0] bm;
      logic        full;
      bm = '0;
      foreach (q[i]) bm[q[i][27:24]] = 1'b1;
      if (m_we) bm[m_dst] = 1'b1;
      full = (q.size() == DEPTH);
      return {!full, !full && !mem_valid, m_we, m_dst, m_data, bm, 4'(q.size())};
   endfunction

   task automatic set_in(input logic r, input logic h,
                         input logic mv, input logic [3:0] md, input logic [23:0] mdat,
                         input logic av, input logic [3:0] ad, input logic [23:0] adat);
      @(negedge clk);
      rst       = r;
      hold      = h;
      mem_valid = mv;
      mem_dst   = md;
      mem_data  = mdat;
      alu_valid = av;
      alu_dst   = ad;
      alu_data  = adat;
      #1;
   endtask

   task automatic idle();
      set_in(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 24'd0);
   endtask

   // Advance one rising edge and apply the behavioural rules to the model.
   task automatic advance();
      logic        full;
      logic [27:0] e;
      full = (q.size() == DEPTH);
      @(posedge clk);
      acc_mem = 1'b0;
      acc_alu = 1'b0;
      if (rst) begin
         q.delete();
         m_we   = 1'b0;
         m_dst  = '0;
         m_data = '0;
      end else begin
         acc_mem = mem_valid && !full;
         acc_alu = alu_valid && !full && !mem_valid;
         if (!hold && q.size() > 0) begin
            e      = q.pop_front();
            m_we   = 1'b1;
            m_dst  = e[27:24];
            m_data = e[23:0];
            wlog.push_back(e);
         end else begin
            m_we = 1'b0;
         end
         if (acc_mem) q.push_back({mem_dst, mem_data});
         else if (acc_alu) q.push_back({alu_dst, alu_data});
      end
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((q.size() > 0 || m_we) && n < 40) begin
         idle();
         total++;
         if (obs !== exp_out()) begin
            bad++;
            $display("FAIL %s_drain cyc%0d got=%h want=%h", name, n, obs, exp_out());
         end
         advance();
         n++;
      end
      total++;
      if (q.size() > 0 || m_we) begin
         bad++;
         $display("FAIL %s_drain timeout: queue=%0d left, want 0", name, q.size());
      end
   endtask

   task automatic test_reset();
      for (int i = 0; i < 2; i++) begin
         set_in(1'b1, 1'($urandom), 1'b1, 4'($urandom), 24'($urandom),
                1'b1, 4'($urandom), 24'($urandom));
         advance();
      end
      idle();
      total++;
      if (obs !== exp_out()) begin
         bad++;
         $display("FAIL reset_model got=%h want=%h", obs, exp_out());
      end
      total++;
      if ({we, dst, data, busy_mask, count} !== 49'd0 || mem_ready !== 1'b1) begin
         bad++;
         $display("FAIL reset_state got we=%b dst=%h data=%h busy=%h count=%0d ready=%b want all zero, ready=1",
                  we, dst, data, busy_mask, count, mem_ready);
      end
   endtask

   task automatic test_single();
      for (int i = 0; i < 5; i++) begin
         if (i == 0) set_in(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 4'd3, 24'h000123);
         else idle();
         total++;
         if (obs !== exp_out()) begin
            bad++;
            $display("FAIL single cyc%0d got=%h want=%h", i, obs, exp_out());
         end
         total++;
         if (we !== (i == 2)) begin
            bad++;
            $display("FAIL single_we cyc%0d got=%b want=%b", i, we, (i == 2));
         end
         if (i == 2) begin
            total++;
            if ({dst, data} !== {4'd3, 24'h000123}) begin
               bad++;
               $display("FAIL single_data got=%h/%h want=3/000123", dst, data);
            end
         end
         if (i >= 1) begin
            total++;
            if (busy_mask !== ((i <= 2) ? 16'h0008 : 16'h0000)) begin
               bad++;
               $display("FAIL single_busy cyc%0d got=%h", i, busy_mask);
            end
         end
         advance();
      end
   endtask

   task automatic test_priority();
      wlog.delete();
      set_in(1'b0, 1'b0, 1'b1, 4'd1, 24'h910000, 1'b1, 4'd2, 24'h2C0002);
      total++;
      if (alu_ready !== 1'b0 || mem_ready !== 1'b1) begin
         bad++;
         $display("FAIL prio_ready got mem=%b alu=%b want mem=1 alu=0", mem_ready, alu_ready);
      end
      advance();
      set_in(1'b0, 1'b0, 1'b0, 4'd0, 24'd0, 1'b1, 4'd2, 24'h2C0002);
      total++;
      if (alu_ready !== 1'b1 || obs !== exp_out()) begin
         bad++;
         $display("FAIL prio_second got=%h want=%h", obs, exp_out());
      end
      advance();
      drain("prio");
      total++;
      if (wlog.size() != 2 || wlog[0] !== {4'd1, 24'h910000} || wlog[1] !== {4'd2, 24'h2C0002}) begin
         bad++;
         $display("FAIL prio_order got %0d writes, want 1/910000 then 2/2C0002", wlog.size());
      end
   endtask

   task automatic test_full_hold();
      logic [27:0] ent [5];
      logic        sent;
      wlog.delete();
      for (int k = 0; k < 5; k++) ent[k] = {4'(k + 4), 24'hA00000 + 24'(k)};
      for (int k = 0; k < 5; k++) begin
         set_in(1'b0, 1'b1, 1'b1, ent[k][27:24], ent[k][23:0], 1'b0, 4'd0, 24'd0);
         total++;
         if (obs !== exp_out()) begin
            bad++;
            $display("FAIL full_fill cyc%0d got=%h want=%h", k, obs, exp_out());
         end
         if (k == 4) begin
            total++;
            if (mem_ready !== 1'b0 || count !== 4'(DEPTH)) begin
               bad++;
               $display("FAIL full_stall got ready=%b count=%0d want ready=0 count=%0d",
                        mem_ready, count, DEPTH);
            end
         end
         advance();
      end
      sent = 1'b0;
      for (int r = 0; r < 8; r++) begin
         if (!sent) set_in(1'b0, 1'b0, 1'b1, ent[4][27:24], ent[4][23:0], 1'b0, 4'd0, 24'd0);
         else idle();
         total++;
         if (obs !== exp_out()) begin
            bad++;
            $display("FAIL full_release cyc%0d got=%h want=%h", r, obs, exp_out());
         end
         if (r >= 1 && r <= 4) begin
            total++;
            if (we !== 1'b1) begin
               bad++;
               $display("FAIL full_pulse cyc%0d got we=%b want 1", r, we);
            end
         end
         advance();
         if (acc_mem) sent = 1'b1;
      end
      drain("full");
      total++;
      if (wlog.size() != 5) begin
         bad++;
         $display("FAIL full_count got %0d writes want 5", wlog.size());
      end else begin
         for (int k = 0; k < 5; k++) begin
            total++;
            if (wlog[k] !== ent[k]) begin
               bad++;
               $display("FAIL full_order idx%0d got=%h want=%h", k, wlog[k], ent[k]);
            end
         end
      end
   endtask

   task automatic test_stream();
      int  s;
      int  n;
      logic port;
      wlog.delete();
      s    = 0;
      n    = 0;
      port = 1'($urandom);
      while (!(s == 10 && q.size() == 0 && !m_we) && n < 200) begin
         if (s < 10)
            set_in(1'b0, $urandom_range(0, 2) == 0,
                   port, 4'(s), 24'(s) * 24'h10, !port, 4'(s), 24'(s) * 24'h10);
         else
            set_in(1'b0, $urandom_range(0, 2) == 0, 1'b0, 4'd0, 24'd0, 1'b0, 4'd0, 24'd0);
         total++;
         if (obs !== exp_out()) begin
            bad++;
            $display("FAIL stream cyc%0d got=%h want=%h", n, obs, exp_out());
         end
         advance();
         if (acc_mem || acc_alu) begin
            s++;
            port = 1'($urandom);
         end
         n++;
      end
      total++;
      if (wlog.size() != 10) begin
         bad++;
         $display("FAIL stream_count got %0d writes want 10", wlog.size());
      end else begin
         for (int k = 0; k < 10; k++) begin
            total++;
            if (wlog[k] !== {4'(k), 24'(k) * 24'h10}) begin
               bad++;
               $display("FAIL stream_order idx%0d got=%h", k, wlog[k]);
            end
         end
      end
   endtask

   task automatic test_reset_mid();
      for (int k = 0; k < 3; k++) begin
         set_in(1'b0, 1'b1, 1'b0, 4'd0, 24'd0, 1'b1, 4'(k + 8), 24'(k) + 24'h5000);
         advance();
      end
      set_in(1'b0, 1'b0, 1'b1, 4'd12, 24'h777777, 1'b0, 4'd0, 24'd0);
      advance();
      set_in(1'b1, 1'b0, 1'b1, 4'd13, 24'h123456, 1'b1, 4'd14, 24'h654321);
      total++;
      if (we !== 1'b1 || count !== 4'd3 || obs !== exp_out()) begin
         bad++;
         $display("FAIL rstmid_pre got we=%b count=%0d want we=1 count=3", we, count);
      end
      advance();
      for (int i = 0; i < 5; i++) begin
         idle();
         total++;
         if (we !== 1'b0 || count !== 4'd0 || busy_mask !== 16'h0000 || obs !== exp_out()) begin
            bad++;
            $display("FAIL rstmid_post cyc%0d got we=%b count=%0d busy=%h want 0/0/0",
                     i, we, count, busy_mask);
         end
         advance();
      end
   endtask

   task automatic test_random();
      for (int i = 0; i < 400; i++) begin
         set_in($urandom_range(0, 39) == 0, $urandom_range(0, 9) < 3,
                1'($urandom), 4'($urandom), 24'($urandom),
                1'($urandom), 4'($urandom), 24'($urandom));
         total++;
         if (obs !== exp_out()) begin
            bad++;
            $display("FAIL random cyc%0d got=%h want=%h", i, obs, exp_out());
         end
         advance();
      end
      drain("random");
   endtask

   initial begin
      total     = 0;
      bad       = 0;
      m_we      = 1'b0;
      m_dst     = '0;
      m_data    = '0;
      acc_mem   = 1'b0;
      acc_alu   = 1'b0;
      rst       = 1'b1;
      hold      = 1'b0;
      mem_valid = 1'b0;
      mem_dst   = '0;
      mem_data  = '0;
      alu_valid = 1'b0;
      alu_dst   = '0;
      alu_data  = '0;

      test_reset();
      test_single();
      test_priority();
      test_full_hold();
      test_stream();
      test_reset_mid();
      test_random();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
